// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/hazard sequencer.
//   state_t  : FSM state encoding (RUN, MDU_BUSY, MEM_WAIT)
//   NOP_INST : instruction word injected into IF/ID on a flush
//   REG_ZERO : hardwired-zero register number, never a hazard source
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0;
    localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// pipe_hazard_cmp
// Combinational load-use hazard detector.
// Ports:
//   id_rs, id_rt         : source registers of the instruction in ID
//   id_use_rs, id_use_rt : ID instruction really reads rs / rt
//   ex_wreg, ex_m2reg    : EX instruction writes a register from memory
//   ex_rd                : destination of the EX instruction
//   hazard               : 1 when ID needs the load result that is not ready yet
module pipe_hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_wreg,
    input  logic       ex_m2reg,
    input  logic [4:0] ex_rd,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_use_rs & (id_rs == ex_rd);
    assign rt_match = id_use_rt & (id_rt == ex_rd);

    // Writes to r0 are discarded, so a load targeting r0 never blocks ID.
    assign hazard = ex_m2reg & ex_wreg & (ex_rd != REG_ZERO) & (rs_match | rt_match);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// Central hazard and stall sequencer for the 5-stage pipeline. Drives every
// pipeline-register enable plus the ID/EX bubble and IF/ID flush selects.
// Event priority in RUN: memory wait > load-use > mul/div start > taken branch.
//
// Optional feature macro: STALL_CTRL_MDU_EN
//   defined   : MDU_BUSY state, 8-bit countdown and mdu_done are built
//   undefined : mdu_start is ignored, mdu_done is 0, FSM is RUN/MEM_WAIT only
//
// Parameters:
//   MDU_CYCLES : stall cycles per multiply/divide (1..255)
// Ports:
//   clk, clrn                : clock, asynchronous active-low reset
//   id_rs, id_rt             : ID source registers
//   id_use_rs, id_use_rt     : ID reads rs / rt
//   ex_wreg, ex_m2reg, ex_rd : EX writeback info (load when ex_m2reg)
//   branch_taken             : ID resolved a taken branch/jump
//   mdu_start                : ID instruction is a multiply/divide
//   mem_req, mem_ready       : MEM access pending / completed
//   wpc, wir, wid, wrest     : PC, IF/ID, ID/EX, EX/MEM+MEM/WB write enables
//   bubble                   : ID/EX loads a NOP
//   flush                    : IF/ID loads a NOP
//   mdu_done                 : pulse in the last MDU busy cycle
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = 32
)
(
    input  logic       clk,
    input  logic       clrn,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_wreg,
    input  logic       ex_m2reg,
    input  logic [4:0] ex_rd,
    input  logic       branch_taken,
    input  logic       mdu_start,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       wpc,
    output logic       wir,
    output logic       wid,
    output logic       wrest,
    output logic       bubble,
    output logic       flush,
    output logic       mdu_done
);

    state_t state;
    state_t state_nxt;
    logic   load_use;
    logic   mem_stall;

`ifdef STALL_CTRL_MDU_EN
    logic [7:0] count;
    logic [7:0] count_nxt;
`else
    logic unused_mdu;
    assign unused_mdu = mdu_start ^ (MDU_CYCLES == 0);
`endif

    pipe_hazard_cmp u_hazard_cmp (
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .ex_wreg   (ex_wreg),
        .ex_m2reg  (ex_m2reg),
        .ex_rd     (ex_rd),
        .hazard    (load_use)
    );

    assign mem_stall = mem_req & ~mem_ready;

    // State and countdown registers; reset drops straight back to RUN even
    // mid-operation so a new mul/div always gets a full countdown.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= RUN;
`ifdef STALL_CTRL_MDU_EN
            count <= 8'd0;
`endif
        end else begin
            state <= state_nxt;
`ifdef STALL_CTRL_MDU_EN
            count <= count_nxt;
`endif
        end
    end

    // Next-state and output decode. An ID stall holds PC and IF/ID and lets
    // the ID/EX register take a bubble so the older instructions drain.
    // A memory wait freezes the whole pipe, so no bubble is needed there.
    always_comb begin
        state_nxt = state;
`ifdef STALL_CTRL_MDU_EN
        count_nxt = count;
`endif
        wpc      = 1'b1;
        wir      = 1'b1;
        wid      = 1'b1;
        wrest    = 1'b1;
        bubble   = 1'b0;
        flush    = 1'b0;
        mdu_done = 1'b0;

        if (!clrn) begin
            wpc       = 1'b0;
            wir       = 1'b0;
            wid       = 1'b0;
            wrest     = 1'b0;
            bubble    = 1'b1;
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        wpc       = 1'b0;
                        wir       = 1'b0;
                        wid       = 1'b0;
                        wrest     = 1'b0;
                        state_nxt = MEM_WAIT;
                    end else if (load_use) begin
                        wpc    = 1'b0;
                        wir    = 1'b0;
                        bubble = 1'b1;
`ifdef STALL_CTRL_MDU_EN
                    end else if (mdu_start) begin
                        wpc       = 1'b0;
                        wir       = 1'b0;
                        bubble    = 1'b1;
                        state_nxt = MDU_BUSY;
                        count_nxt = 8'(MDU_CYCLES - 1);
`endif
                    end else if (branch_taken) begin
                        flush = 1'b1;
                    end
                end

                MEM_WAIT: begin
                    // Completion cycle already behaves like a normal RUN cycle.
                    if (!mem_ready) begin
                        wpc   = 1'b0;
                        wir   = 1'b0;
                        wid   = 1'b0;
                        wrest = 1'b0;
                    end else begin
                        state_nxt = RUN;
                    end
                end

`ifdef STALL_CTRL_MDU_EN
                MDU_BUSY: begin
                    if (mem_stall) begin
                        wpc   = 1'b0;
                        wir   = 1'b0;
                        wid   = 1'b0;
                        wrest = 1'b0;
                    end else begin
                        wpc    = 1'b0;
                        wir    = 1'b0;
                        bubble = 1'b1;
                        if (count == 8'd0) begin
                            mdu_done  = 1'b1;
                            state_nxt = RUN;
                        end else begin
                            count_nxt = count - 8'd1;
                        end
                    end
                end
`endif

                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl
// Scoreboard bench for pipe_stall_ctrl. The driver applies one input vector
// per cycle and pushes the reference model's expected outputs into a queue;
// an independent monitor pops one entry per cycle and compares.
// Optional macro: STALL_CTRL_MDU_EN (must match the RTL build).
module tb_pipe_stall_ctrl;

    localparam int MDU_N = 4;
`ifdef STALL_CTRL_MDU_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif

    // Output vector order: {wpc, wir, wid, wrest, bubble, flush, mdu_done}
    localparam logic [6:0] O_RESET = 7'b0000100;
    localparam logic [6:0] O_RUN   = 7'b1111000;
    localparam logic [6:0] O_FREEZ = 7'b0000000;
    localparam logic [6:0] O_STALL = 7'b0011100;

    typedef struct {
        logic       clrn;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_use_rs;
        logic       id_use_rt;
        logic       ex_wreg;
        logic       ex_m2reg;
        logic [4:0] ex_rd;
        logic       branch_taken;
        logic       mdu_start;
        logic       mem_req;
        logic       mem_ready;
    } stim_t;

    typedef struct {
        logic [6:0] outs;
        string      tag;
    } exp_t;

    logic       clk;
    logic       clrn;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       ex_wreg;
    logic       ex_m2reg;
    logic [4:0] ex_rd;
    logic       branch_taken;
    logic       mdu_start;
    logic       mem_req;
    logic       mem_ready;
    logic       wpc;
    logic       wir;
    logic       wid;
    logic       wrest;
    logic       bubble;
    logic       flush;
    logic       mdu_done;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;
    bit   drive_done = 1'b0;

    // Reference model: "am I waiting on memory" and "how many mul/div busy
    // cycles are still owed".
    bit m_waiting = 1'b0;
    int m_left    = 0;

    pipe_stall_ctrl #(.MDU_CYCLES(MDU_N)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .ex_wreg      (ex_wreg),
        .ex_m2reg     (ex_m2reg),
        .ex_rd        (ex_rd),
        .branch_taken (branch_taken),
        .mdu_start    (mdu_start),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .wpc          (wpc),
        .wir          (wir),
        .wid          (wid),
        .wrest        (wrest),
        .bubble       (bubble),
        .flush        (flush),
        .mdu_done     (mdu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] model_step(input stim_t s);
        logic [6:0] e;
        bit lu;
        bit ms;
        if (!s.clrn) begin
            m_waiting = 1'b0;
            m_left    = 0;
            return O_RESET;
        end
        e  = O_RUN;
        ms = s.mem_req && !s.mem_ready;
        lu = s.ex_m2reg && s.ex_wreg && (s.ex_rd != 5'd0) &&
             ((s.id_use_rs && s.id_rs == s.ex_rd) || (s.id_use_rt && s.id_rt == s.ex_rd));
        if (m_waiting) begin
            if (!s.mem_ready) e = O_FREEZ;
            else m_waiting = 1'b0;
        end else if (m_left > 0) begin
            if (ms) begin
                e = O_FREEZ;
            end else begin
                e = O_STALL;
                m_left--;
                if (m_left == 0) e[0] = 1'b1;
            end
        end else if (ms) begin
            e = O_FREEZ;
            m_waiting = 1'b1;
        end else if (lu) begin
            e = O_STALL;
        end else if (MDU_EN && s.mdu_start) begin
            e = O_STALL;
            m_left = MDU_N;
        end else if (s.branch_taken) begin
            e[1] = 1'b1;
        end
        return e;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s.clrn = 1'b1;
        s.id_rs = 5'd0;
        s.id_rt = 5'd0;
        s.id_use_rs = 1'b0;
        s.id_use_rt = 1'b0;
        s.ex_wreg = 1'b0;
        s.ex_m2reg = 1'b0;
        s.ex_rd = 5'd0;
        s.branch_taken = 1'b0;
        s.mdu_start = 1'b0;
        s.mem_req = 1'b0;
        s.mem_ready = 1'b0;
        return s;
    endfunction

    function automatic stim_t load_use_stim(input logic [4:0] rd);
        stim_t s;
        s = idle_stim();
        s.ex_m2reg  = 1'b1;
        s.ex_wreg   = 1'b1;
        s.ex_rd     = rd;
        s.id_rs     = rd;
        s.id_use_rs = 1'b1;
        return s;
    endfunction

    function automatic stim_t random_stim();
        stim_t s;
        s.clrn         = ($urandom_range(0, 49) != 0);
        s.id_rs        = 5'($urandom_range(0, 3));
        s.id_rt        = 5'($urandom_range(0, 3));
        s.id_use_rs    = 1'($urandom_range(0, 1));
        s.id_use_rt    = 1'($urandom_range(0, 1));
        s.ex_wreg      = 1'($urandom_range(0, 1));
        s.ex_m2reg     = 1'($urandom_range(0, 1));
        s.ex_rd        = 5'($urandom_range(0, 3));
        s.branch_taken = ($urandom_range(0, 3) == 0);
        s.mdu_start    = ($urandom_range(0, 7) == 0);
        s.mem_req      = ($urandom_range(0, 4) == 0);
        s.mem_ready    = ($urandom_range(0, 9) < 6);
        return s;
    endfunction

    // Drive one cycle's inputs just after the rising edge and queue the
    // expected response; the monitor samples it on the following falling edge.
    task automatic applyStimulus(input stim_t s, input string tag);
        exp_t e;
        clrn         = s.clrn;
        id_rs        = s.id_rs;
        id_rt        = s.id_rt;
        id_use_rs    = s.id_use_rs;
        id_use_rt    = s.id_use_rt;
        ex_wreg      = s.ex_wreg;
        ex_m2reg     = s.ex_m2reg;
        ex_rd        = s.ex_rd;
        branch_taken = s.branch_taken;
        mdu_start    = s.mdu_start;
        mem_req      = s.mem_req;
        mem_ready    = s.mem_ready;
        e.outs = model_step(s);
        e.tag  = tag;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [6:0] got;
        got = {wpc, wir, wid, wrest, bubble, flush, mdu_done};
        checks++;
        if (got !== e.outs) begin
            errors++;
            $display("[TB] FAIL %s: got {wpc,wir,wid,wrest,bubble,flush,mdu_done}=%b expected %b",
                     e.tag, got, e.outs);
        end
    endtask

    // Monitor: one queued expectation per cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput(e);
            end
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        stim_t s;
        s = idle_stim();
        s.clrn = 1'b0;
        clrn = 1'b0;
        id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
        ex_wreg = 0; ex_m2reg = 0; ex_rd = '0; branch_taken = 0;
        mdu_start = 0; mem_req = 0; mem_ready = 0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) applyStimulus(s, "reset_hold");
        applyStimulus(idle_stim(), "post_reset_idle");
        applyStimulus(idle_stim(), "idle");

        applyStimulus(load_use_stim(5'd5), "load_use_rs5");
        applyStimulus(idle_stim(), "load_use_release");
        applyStimulus(load_use_stim(5'd0), "load_use_rd0");
        s = load_use_stim(5'd7);
        s.id_use_rs = 1'b0;
        s.id_rs = 5'd0;
        s.id_rt = 5'd7;
        s.id_use_rt = 1'b1;
        applyStimulus(s, "load_use_rt7");
        s.ex_m2reg = 1'b0;
        applyStimulus(s, "alu_no_stall");

        s = idle_stim();
        s.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(s, "mem_wait");
        s.mem_ready = 1'b1;
        applyStimulus(s, "mem_ready");
        applyStimulus(idle_stim(), "after_mem");

        s = load_use_stim(5'd3);
        s.branch_taken = 1'b1;
        applyStimulus(s, "branch_with_load_use");
        s = idle_stim();
        s.branch_taken = 1'b1;
        applyStimulus(s, "branch_alone");

        s = idle_stim();
        s.mdu_start = 1'b1;
        applyStimulus(s, "mdu_start");
        for (int i = 0; i < 5; i++) applyStimulus(idle_stim(), "mdu_busy");

        s = idle_stim();
        s.mdu_start = 1'b1;
        applyStimulus(s, "mdu_start2");
        applyStimulus(idle_stim(), "mdu_busy2");
        applyStimulus(idle_stim(), "mdu_busy2");
        s = idle_stim();
        s.clrn = 1'b0;
        applyStimulus(s, "mdu_mid_reset");
        s = idle_stim();
        s.mdu_start = 1'b1;
        applyStimulus(s, "mdu_restart");
        s = idle_stim();
        s.mem_req = 1'b1;
        s.mdu_start = 1'b1;
        applyStimulus(s, "mdu_mem_freeze");
        applyStimulus(s, "mdu_mem_freeze");
        for (int i = 0; i < 5; i++) applyStimulus(idle_stim(), "mdu_after_freeze");

        for (int i = 0; i < 600; i++) applyStimulus(random_stim(), "random");

        @(negedge clk);
        @(negedge clk);
        drive_done = 1'b1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central hazard and stall sequencer for the 5-stage pipeline. It generates the write enables for the PC, the IF/ID instruction register (`wir`) and the ID/EX register. It also generates bubble and flush controls. It resolves load-use hazards, taken-branch flushes, multi-cycle multiply/divide occupancy and data-memory wait states, in a fixed priority. It sits beside the decode stage and drives every pipeline-register enable.

## Interface
Parameters:
- MDU_CYCLES, 32, number of stall cycles for one multiply/divide operation; legal range is 1..255.

Ports:
- clk  in  1  clock.
- clrn  in  1  reset; asynchronous, active-low.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_use_rs, id_use_rt  in  1 each  the ID instruction actually reads rs or rt.
- ex_wreg, ex_m2reg  in  1 each  the EX instruction writes a register, and that write comes from memory (a load).
- ex_rd  in  5  destination register of the EX instruction.
- branch_taken  in  1  ID has resolved a taken branch or jump.
- mdu_start  in  1  the ID instruction is a multiply/divide.
- mem_req, mem_ready  in  1 each  MEM-stage access is pending, and the data memory has completed it.
- wpc  out  1  PC write enable.
- wir  out  1  IF/ID write enable.
- wid  out  1  ID/EX write enable.
- wrest  out  1  EX/MEM and MEM/WB write enable.
- bubble  out  1  ID/EX loads a NOP (all control bits 0) instead of decoded controls.
- flush  out  1  IF/ID loads a NOP (32'h0) instead of the fetched word.
- mdu_done  out  1  one-cycle pulse in the last MDU busy cycle.

## Operation
- The FSM has 3 states: RUN, MDU_BUSY and MEM_WAIT. The state register and the 8-bit countdown are reset asynchronously. All outputs are combinational from the state, the count and the inputs.
- While clrn=0, the state is RUN and the count is 0. Outputs are forced to wpc=0, wir=0, wid=0, wrest=0, bubble=1, flush=0 and mdu_done=0.
- Default in RUN with no event: wpc=wir=wid=wrest=1, bubble=flush=0.
- Priority inside RUN, highest first:
  1. mem_req=1 and mem_ready=0: all four enables are 0 and bubble=0. The next state is MEM_WAIT.
  2. Load-use hazard: ex_m2reg & ex_wreg & (ex_rd≠0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)). Outputs are wpc=0, wir=0, wid=1, bubble=1, wrest=1. The state stays RUN.
  3. mdu_start=1: same outputs as the load-use stall. The next state is MDU_BUSY and the count loads MDU_CYCLES-1.
  4. branch_taken=1: flush=1 and all enables are 1.
- MEM_WAIT:
  - All enables are 0 while mem_ready=0.
  - When mem_ready=1, the RUN default outputs apply in that same cycle and the next state is RUN.
  - Hazard inputs are ignored while waiting.
- MDU_BUSY:
  - Outputs are wpc=0, wir=0, wid=1, bubble=1, wrest=1.
  - The count decrements each cycle.
  - When count==0, mdu_done=1 and the next state is RUN.
  - A mem_req/!mem_ready in MDU_BUSY freezes the countdown (all enables 0) but stays in MDU_BUSY.
- branch_taken and mdu_start are ignored whenever ID is stalled. The held instruction re-presents them after the stall releases.
- ex_rd==0 never causes a stall.

## Timing
- Load-use stall lasts exactly 1 cycle. The hazard clears once the load advances to MEM.
- The MDU stall holds ID for exactly MDU_CYCLES cycles after the mdu_start cycle, plus any frozen memory-wait cycles.
- A memory stall lasts for the number of cycles mem_ready is low.
- A flush costs 1 slot: the fetched word is replaced by a NOP on the same edge.
- Reset mid-MDU or mid-MEM_WAIT returns the block to RUN immediately, asynchronously.

## Configuration
- STALL_CTRL_MDU_EN defined: MDU_BUSY, the countdown and mdu_done are present.
- Undefined: mdu_start is ignored, mdu_done is tied to 0, and the FSM has only RUN and MEM_WAIT.

## Structure
- pipe_ctrl_pkg holds the state enum (RUN=2'd0, MDU_BUSY=2'd1, MEM_WAIT=2'd2), NOP_INST=32'h0 and REG_ZERO=5'd0.
- One sub-module, pipe_hazard_cmp, is the combinational load-use comparator producing a single hazard bit.

## Test plan
- Reset: hold clrn=0 for 3 cycles -> wpc=0, wir=0, bubble=1. After release with idle inputs -> wpc=wir=wid=wrest=1.
- Load-use: ex_m2reg=1, ex_wreg=1, ex_rd=5, id_rs=5, id_use_rs=1 for one cycle -> wpc=0, wir=0, bubble=1 for exactly 1 cycle. Repeating with ex_rd=0 -> no stall.
- MDU, with the macro defined and MDU_CYCLES=4: pulse mdu_start -> 4 cycles of wir=0, bubble=1, then mdu_done=1 in the 4th cycle and RUN after it.
- Memory: mem_req=1 with mem_ready=0 for 3 cycles -> all enables 0 for 3 cycles. Enables return in the cycle mem_ready=1.
- Simultaneous events:
  - branch_taken together with a load-use hazard -> stall only, flush=0.
  - The next cycle, branch_taken alone -> flush=1.
- Reset mid-MDU: clrn low at count=2 -> the next mdu_start begins a full 4-cycle stall.
